// File: rtl/demux_1to4_reg.sv
// demux_1to4_reg: routes one W-bit word to one of four registered valid/ready channels
// and keeps a saturating delivery counter per channel.
module demux_1to4_reg #(
    parameter int W  = 2,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    in_data,
    input  logic            s0,
    input  logic            s1,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [4*W-1:0]  out_data,
    output logic [3:0]      out_valid,
    input  logic [3:0]      out_ready,
    input  logic            cnt_clr,
    output logic [4*CW-1:0] cnt,
    output logic            busy
);
    logic [1:0]    sel;
    logic [3:0]    full;
    logic [3:0]    drain;
    logic          acc;
    logic [W-1:0]  data [4];
    logic [CW-1:0] count [4];

    assign sel       = {s0, s1};
    assign in_ready  = !full[sel] || out_ready[sel];
    assign acc       = in_valid && in_ready;
    assign drain     = full & out_ready;
    assign out_valid = full;
    assign busy      = |full;

    for (genvar k = 0; k < 4; k++) begin : g_ch
        // a load on the same edge as a drain keeps the slot full
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                full[k] <= 1'b0;
                data[k] <= '0;
            end else if (acc && sel == 2'(k)) begin
                full[k] <= 1'b1;
                data[k] <= in_data;
            end else if (drain[k]) begin
                full[k] <= 1'b0;
            end
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                count[k] <= '0;
            else if (cnt_clr)
                count[k] <= '0;
            else if (drain[k] && count[k] != '1)
                count[k] <= count[k] + 1'b1;
        end
        assign out_data[k*W +: W] = data[k];
        assign cnt[k*CW +: CW]    = count[k];
    end
endmodule

// File: tb/tb_demux_1to4_reg.sv
// tb_demux_1to4_reg: table-driven check of routing, back-pressure, saturation and async reset.
module tb_demux_1to4_reg;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] in_data = '0;
    logic       s0 = 1'b0, s1 = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic [3:0] out_valid;
    logic [3:0] out_ready = '0;
    logic       cnt_clr = 1'b0;
    logic [7:0] cnt;
    logic       busy;
    int         n_cmp = 0;
    int         n_err = 0;

    demux_1to4_reg #(.W(2), .CW(2)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .s0(s0), .s1(s1),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .cnt_clr(cnt_clr),
        .cnt(cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [1:0] sel;
        logic [1:0] d;
        logic [3:0] ordy;
        logic       clr;
        logic       rdy;
        logic [3:0] ov;
        logic [7:0] od;
        logic [7:0] oc;
    } vec_t;

    vec_t tbl [20];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input int i);
        @(negedge clk);
        in_valid  = tbl[i].iv;
        {s0, s1}  = tbl[i].sel;
        in_data   = tbl[i].d;
        out_ready = tbl[i].ordy;
        cnt_clr   = tbl[i].clr;
        #1 check("in_ready", i, 32'(in_ready), 32'(tbl[i].rdy));
        @(posedge clk);
        #1;
        check("out_valid", i, 32'(out_valid), 32'(tbl[i].ov));
        check("out_data", i, 32'(out_data), 32'(tbl[i].od));
        check("cnt", i, 32'(cnt), 32'(tbl[i].oc));
        check("busy", i, 32'(busy), 32'(tbl[i].ov != 4'h0));
    endtask

    initial begin
        // iv sel d ordy clr | rdy ov od oc
        tbl[0]  = '{1'b1, 2'd0, 2'd0, 4'hF, 1'b0, 1'b1, 4'h1, 8'h00, 8'h00};
        tbl[1]  = '{1'b1, 2'd1, 2'd1, 4'hF, 1'b0, 1'b1, 4'h2, 8'h04, 8'h01};
        tbl[2]  = '{1'b1, 2'd2, 2'd2, 4'hF, 1'b0, 1'b1, 4'h4, 8'h24, 8'h05};
        tbl[3]  = '{1'b1, 2'd3, 2'd3, 4'hF, 1'b0, 1'b1, 4'h8, 8'hE4, 8'h15};
        tbl[4]  = '{1'b0, 2'd3, 2'd0, 4'hF, 1'b0, 1'b1, 4'h0, 8'hE4, 8'h55};
        tbl[5]  = '{1'b1, 2'd2, 2'd2, 4'h0, 1'b0, 1'b1, 4'h4, 8'hE4, 8'h55};
        tbl[6]  = '{1'b1, 2'd2, 2'd3, 4'h0, 1'b0, 1'b0, 4'h4, 8'hE4, 8'h55};
        tbl[7]  = '{1'b1, 2'd1, 2'd3, 4'h0, 1'b0, 1'b1, 4'h6, 8'hEC, 8'h55};
        tbl[8]  = '{1'b1, 2'd3, 2'd1, 4'h0, 1'b0, 1'b1, 4'hE, 8'h6C, 8'h55};
        tbl[9]  = '{1'b1, 2'd3, 2'd2, 4'h8, 1'b0, 1'b1, 4'hE, 8'hAC, 8'h95};
        tbl[10] = '{1'b0, 2'd3, 2'd0, 4'h0, 1'b1, 1'b0, 4'hE, 8'hAC, 8'h00};
        tbl[11] = '{1'b1, 2'd0, 2'd1, 4'h1, 1'b0, 1'b1, 4'hF, 8'hAD, 8'h00};
        tbl[12] = '{1'b1, 2'd0, 2'd2, 4'h1, 1'b0, 1'b1, 4'hF, 8'hAE, 8'h01};
        tbl[13] = '{1'b1, 2'd0, 2'd3, 4'h1, 1'b0, 1'b1, 4'hF, 8'hAF, 8'h02};
        tbl[14] = '{1'b1, 2'd0, 2'd0, 4'h1, 1'b0, 1'b1, 4'hF, 8'hAC, 8'h03};
        tbl[15] = '{1'b1, 2'd0, 2'd1, 4'h1, 1'b0, 1'b1, 4'hF, 8'hAD, 8'h03};
        tbl[16] = '{1'b1, 2'd0, 2'd2, 4'h1, 1'b0, 1'b1, 4'hF, 8'hAE, 8'h03};
        tbl[17] = '{1'b0, 2'd0, 2'd0, 4'h1, 1'b1, 1'b1, 4'hE, 8'hAE, 8'h00};
        tbl[18] = '{1'b0, 2'd0, 2'd0, 4'h1, 1'b0, 1'b1, 4'hE, 8'hAE, 8'h00};
        tbl[19] = '{1'b1, 2'd0, 2'd3, 4'h0, 1'b0, 1'b1, 4'hF, 8'hAF, 8'h00};

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", -1, 32'(out_valid), 32'h0);
        check("rst_cnt", -1, 32'(cnt), 32'h0);
        check("rst_busy", -1, 32'(busy), 32'h0);
        check("rst_data", -1, 32'(out_data), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) apply(i);

        // asynchronous reset between edges with every channel full
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 4'h0;
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 20, 32'(out_valid), 32'h0);
        check("arst_busy", 20, 32'(busy), 32'h0);
        check("arst_data", 20, 32'(out_data), 32'h0);
        check("arst_cnt", 20, 32'(cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) apply(i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/demux_1to4_reg.md
Name: demux_1to4_reg

Overview:
- Inverse of the 4:1 selector: steers one W-bit input word to one of four output channels.
- Channel chosen by {s0,s1}, same encoding as the 4:1 mux: 00→ch0(a), 01→ch1(b), 10→ch2(c), 11→ch3(d).
- Each channel has a one-entry holding register with a valid/ready handshake, plus a saturating delivered-word counter.
- Sits downstream of a producer that needs to fan data out to four consumers with independent back-pressure.

Parameters:
W, 2, data width per word/channel.
CW, 8, width of each per-channel delivery counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset; asynchronous, active-high.
in_data  input  W  word to route.
s0  input  1  select MSB; the channel index is {s0,s1}.
s1  input  1  select LSB.
in_valid  input  1  producer has a word.
in_ready  output  1  block can accept the word this cycle.
out_data  output  4*W  channel data, packed; ch0 in bits [W-1:0], chk in bits [k*W+W-1:k*W].
out_valid  output  4  bit k: channel k holds a word.
out_ready  input  4  bit k: consumer k takes the word this cycle.
cnt_clr  input  1  synchronous clear of all counters.
cnt  output  4*CW  packed delivery counters; ch0 at the LSBs.
busy  output  1  OR of all out_valid bits.

Behaviour:
- Reset (async assert, any time, including mid-transfer):
  - all full_k flags = 0, so out_valid = 0000, busy = 0;
  - all data registers = 0, so out_data = 0;
  - all counters = 0.
  - In-flight words are discarded. First accept is possible on the first rising edge after rst deasserts.
- sel = {s0,s1}. It is sampled only on an accept edge. sel may change freely while in_valid is high and in_ready is low, and in_ready then follows the new sel.
- in_ready = !full_sel || out_ready[sel].
  - Combinational, depends only on state, sel and out_ready; in_valid does not enter into it.
  - It may be high with in_valid low.
- Accept: in_valid && in_ready at a rising edge. data_sel <= in_data and full_sel <= 1.
- Latency: the word appears on out_data/out_valid of the selected channel in the cycle after the accept. There is no combinational path from in_data to out_data.
- Drain on channel k: full_k && out_ready[k] at an edge. full_k <= 0 unless the same edge accepts into k.
- Simultaneous drain and accept on the same channel: the old word is delivered and the new word is loaded; full_k stays 1. This gives one word per cycle of throughput per channel.
- Non-selected channels drain independently in the same cycle as an accept. All four channels may drain on the same edge.
- out_ready[k] while full_k = 0: ignored; no state change, no count.
- Data registers are held when not loading. Data is not cleared on drain.
- Counter k:
  - increments by 1 on each drain of channel k;
  - saturates at 2^CW−1 and does not wrap.
- cnt_clr:
  - clears all counters to 0 on the edge;
  - has priority over increment on the same edge (result is 0, not 1);
  - does not affect data or full flags.
- in_valid with in_ready low: no state change. The producer must hold the word; no loss, no duplication.
- Unknown (X/Z) on s0/s1 is out of scope.

Test Plan:
1. Reset then routing: after reset, out_valid=0000, cnt=0 and busy=0.
   - With all out_ready=1, send 00 with {s0,s1}=00, then 01 with =01, then 10 with =10, then 11 with =11.
   - Required: each word appears on its channel one cycle after accept (ch0=00, ch1=01, ch2=10, ch3=11).
   - Required: in_ready stays 1 throughout; each counter reads 1 at the end.
2. Back-pressure: out_ready=0000; accept 10 into ch2; hold in_valid with sel=10 and data 11.
   - Required: in_ready=0, ch2 keeps 10, out_valid=0100.
   - Change sel to 01: in_ready goes to 1 and 11 lands on ch1, out_valid=0110.
3. Simultaneous drain and load: ch3 full with 01, out_ready[3]=1, accept 10 to ch3 on the same edge.
   - Required: cnt3 +1, ch3 data=10, out_valid[3] stays 1.
4. Saturation and clear with CW=2: drain ch0 five times.
   - Required: cnt0 = 1, 2, 3, 3, 3.
   - Assert cnt_clr on the same edge as a further ch0 drain: required cnt0=0.
5. Async reset mid-operation: all channels full, assert rst between edges.
   - Required: out_valid=0000, busy=0 and out_data=0 immediately, without waiting for a clock edge.
   - After deassert, the first accept behaves as in scenario 1.
